// File: rtl/peak_ctrl_pkg.sv
// rtl/peak_ctrl_pkg.sv - shared FSM state type and default widths for the peak capture controller
package peak_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int TS_W_DEF   = 16;
  localparam int HOLD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int TO_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT    = 3'd2,
    S_HOLDOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/peak_out_slot.sv
// rtl/peak_out_slot.sv - single-entry valid/ready result register, load wins over drain, sticky overflow
module peak_out_slot #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TS_W-1:0]   i_time,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [TS_W-1:0]   o_time,
  output logic              o_overflow
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [TS_W-1:0]   r_time;
  logic              r_ovf;
  logic              w_drop;

  // A load only loses when the slot is full and nobody is draining it this cycle.
  assign w_drop = i_load && r_valid && !i_ready;

  // Slot contents: load (including load-during-drain) first, plain drain otherwise.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_time  <= '0;
    end else if (i_load && !w_drop) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_time  <= i_time;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky drop flag, cleared only when a new session is armed.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_ovf <= 1'b0;
    else if (i_clr)  r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_time     = r_time;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/peak_capture_ctrl.sv
// rtl/peak_capture_ctrl.sv - PeakDetector session sequencer; optional timeout under PEAK_CTRL_TIMEOUT_EN
module peak_capture_ctrl
  import peak_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
`ifdef PEAK_CTRL_TIMEOUT_EN
  ,
  parameter int TO_W   = TO_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfgMinLevel,
  input  logic [HOLD_W-1:0] cfgHoldoff,
  input  logic [CNT_W-1:0]  cfgNumPeaks,
  output logic              pdRst,
  output logic              pdEnable,
  output logic [DATA_W-1:0] pdMinLevel,
  input  logic              pkDetected,
  input  logic [DATA_W-1:0] pdDOut,
  output logic              peakValid,
  input  logic              peakReady,
  output logic [DATA_W-1:0] peakData,
  output logic [TS_W-1:0]   peakTime,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef PEAK_CTRL_TIMEOUT_EN
  ,
  input  logic [TO_W-1:0]   cfgTimeout,
  output logic              timedOut
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_min_level;
  logic [HOLD_W-1:0] r_holdoff;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_num_peaks;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [TS_W-1:0]   r_ts;
  logic              r_done;
  logic              w_arm_ok;
  logic              w_peak;
  logic              w_cnt_hit;
  logic              w_hold_end;
  logic              w_to_hit;

  assign w_arm_ok   = (r_state == S_IDLE) && arm && !abort;
  assign w_peak     = (r_state == S_WAIT) && pkDetected && !abort;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_hit  = (r_num_peaks != '0) && (w_cnt_inc == r_num_peaks);
  assign w_hold_end = (r_hold_cnt == r_holdoff - HOLD_W'(1));

`ifdef PEAK_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] r_timeout;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timed_out;

  assign w_to_hit = (r_state == S_WAIT) && !pkDetected && (r_timeout != '0) &&
                    (r_to_cnt == r_timeout - TO_W'(1));
  assign timedOut = r_timed_out;

  // WAIT-cycle counter restarts on every WAIT entry and after every accepted peak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout   <= '0;
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_timeout   <= cfgTimeout;
        r_timed_out <= 1'b0;
      end else if (w_to_hit && !abort) begin
        r_timed_out <= 1'b1;
      end
      if (r_state == S_WAIT && !pkDetected) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                  r_to_cnt <= '0;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and detector/session outputs decoded from the current state.
  always_comb begin
    w_next   = r_state;
    pdRst    = 1'b0;
    pdEnable = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (arm) w_next = S_CLEAR;
      S_CLEAR: begin
        pdRst  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        pdEnable = 1'b1;
        if (pkDetected) begin
          if (w_cnt_hit)              w_next = S_DONE;
          else if (r_holdoff != '0)   w_next = S_HOLDOFF;
        end else if (w_to_hit) begin
          w_next = S_DONE;
        end
      end
      S_HOLDOFF: if (w_hold_end) w_next = S_WAIT;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Session datapath: config latch, timestamp, peak count, holdoff timer, done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min_level <= '0;
      r_holdoff   <= '0;
      r_num_peaks <= '0;
      r_cnt       <= '0;
      r_ts        <= '0;
      r_hold_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE) && !abort;
      if (w_arm_ok) begin
        r_min_level <= cfgMinLevel;
        r_holdoff   <= cfgHoldoff;
        r_num_peaks <= cfgNumPeaks;
        r_cnt       <= '0;
        r_ts        <= '0;
      end else if ((r_state == S_WAIT || r_state == S_HOLDOFF) && r_ts != '1) begin
        r_ts <= r_ts + TS_W'(1);
      end
      if (w_peak) r_cnt <= w_cnt_inc;
      if (r_state == S_HOLDOFF) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      else                      r_hold_cnt <= '0;
    end
  end

  assign pdMinLevel = r_min_level;
  assign done       = r_done;

  peak_out_slot #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W)
  ) u_slot (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_clr      (w_arm_ok),
    .i_load     (w_peak),
    .i_data     (pdDOut),
    .i_time     (r_ts),
    .i_ready    (peakReady),
    .o_valid    (peakValid),
    .o_data     (peakData),
    .o_time     (peakTime),
    .o_overflow (overflow)
  );

endmodule

// File: doc/peak_capture_ctrl.md
# peak_capture_ctrl

Sequencing controller for the `PeakDetector` datapath in the acquisition path. It arms the detector with a latched threshold and clears it, then collects a programmed number of peaks. Each peak is timestamped and the detector is blanked for a holdoff window after it. Results go to the downstream consumer over a single-entry valid/ready port.

## Interface
Parameters:
- `DATA_W`, 8: sample / threshold width; matches `PeakDetector` `DIn`/`DOut`.
- `TS_W`, 16: timestamp width.
- `HOLD_W`, 8: holdoff counter width.
- `CNT_W`, 8: peak count width.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `arm`, in, 1: single-cycle start of a capture session; ignored while `busy`.
- `abort`, in, 1: ends the session from any state.
- `cfgMinLevel`, in, `DATA_W`: detection threshold; latched on accepted `arm`.
- `cfgHoldoff`, in, `HOLD_W`: blanking cycles after each peak; latched on accepted `arm`.
- `cfgNumPeaks`, in, `CNT_W`: peaks per session, where 0 means unlimited; latched on accepted `arm`.
- `pdRst`, out, 1: active-high synchronous reset to `PeakDetector`.
- `pdEnable`, out, 1: `PeakDetector` enable.
- `pdMinLevel`, out, `DATA_W`: latched threshold to `PeakDetector`.
- `pkDetected`, in, 1: peak strobe from `PeakDetector`.
- `pdDOut`, in, `DATA_W`: peak value from `PeakDetector`, valid while `pkDetected`=1.
- `peakValid`, out, 1: result slot full.
- `peakReady`, in, 1: consumer accepts.
- `peakData`, out, `DATA_W`: captured peak value.
- `peakTime`, out, `TS_W`: timestamp of the captured peak.
- `busy`, out, 1: session in progress, meaning any state other than IDLE.
- `done`, out, 1: one-cycle pulse at session end.
- `overflow`, out, 1: sticky; a peak was dropped. Cleared only on accepted `arm` or reset.

## Operation
- Reset values: all outputs are 0, the state is IDLE, and every counter is 0.
- FSM states are IDLE, CLEAR, WAIT, HOLDOFF and DONE.
- IDLE:
  - `pdEnable`=0.
  - `arm` latches the config, clears `overflow`, the peak count and the timestamp, then moves to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle, with `pdRst`=1 and `pdEnable`=0.
  - Always moves to WAIT.
- WAIT:
  - `pdEnable`=1.
  - The timestamp increments every cycle and saturates at all-ones.
  - On `pkDetected`=1, the peak count increments, then:
    - to DONE if `cfgNumPeaks`≠0 and the new count equals `cfgNumPeaks`;
    - otherwise to HOLDOFF if `cfgHoldoff`≠0;
    - otherwise stay in WAIT.
  - With `cfgNumPeaks`=0 the count is not compared and wraps modulo 2^`CNT_W`.
- HOLDOFF:
  - `pdEnable`=0.
  - Lasts exactly `cfgHoldoff` cycles, then returns to WAIT.
  - The timestamp keeps counting.
  - `pkDetected` is ignored.
- DONE: pulses `done` for 1 cycle, then moves to IDLE.
- Result slot:
  - A peak accepted in WAIT loads `peakData`←`pdDOut` and `peakTime`←timestamp, and sets `peakValid`.
  - If the slot is full and not being drained in the same cycle, the peak is dropped and `overflow` is set. The drop still counts toward `cfgNumPeaks`.
- Transfers occur when `peakValid`&&`peakReady`.
  - If a drain and a load happen in the same cycle, the load wins: `peakValid` stays 1 with the new data, and no overflow is flagged.
- `abort`:
  - Highest priority; the next state is IDLE.
  - `pdEnable`=0 next cycle, and no `done` pulse.
  - The result slot and `overflow` are preserved.
- If `arm` and `abort` arrive in the same cycle in IDLE, `abort` wins and the session does not start.

## Timing
- From `arm` to `pdRst`: 1 cycle. `pdEnable` rises 2 cycles after `arm`.
- The first WAIT cycle has timestamp 0.
- From `pkDetected` to `peakValid`/`peakData`/`peakTime` updated: 1 cycle, registered.
- `pdEnable` falls the cycle after the peak that enters HOLDOFF or DONE.
- After a peak, `pdEnable` is 0 for exactly `cfgHoldoff` cycles.
- `done` is asserted the cycle after entering DONE, and `busy` falls in the same cycle.
- If reset is asserted mid-session, all outputs return to their reset values immediately.

## Configuration
- Macro `PEAK_CTRL_TIMEOUT_EN`. When defined:
  - Adds parameter `TO_W` (default 16), input `cfgTimeout` [`TO_W`], latched on `arm`, and output `timedOut`, which is sticky and cleared on `arm`.
  - In WAIT, a counter that restarts on each WAIT entry reaches `cfgTimeout`≠0 without a peak: the FSM goes to DONE and sets `timedOut`.
  - `cfgTimeout`=0 disables the timeout.
- When undefined, the ports and counter are absent and WAIT waits indefinitely.

## Structure
- Shared package `peak_ctrl_pkg`: the FSM state enum (IDLE, CLEAR, WAIT, HOLDOFF, DONE) and the default width constants.
- One sub-module, `peak_out_slot`: the single-entry valid/ready register with load-wins-over-drain and overflow detection.

## Test plan
- `cfgMinLevel`=128, `cfgNumPeaks`=2, `cfgHoldoff`=3; peaks of 130 at timestamps 5 and 20, consumer always ready → two transfers, (130,5) and (130,20); `done` 1 cycle after the second; `overflow`=0.
- `cfgHoldoff`=4, a peak followed 2 cycles later by another `pkDetected` → the second is ignored, `pdEnable` is low for exactly 4 cycles, count=1.
- `peakReady`=0 with two peaks → first result held, `overflow`=1; `peakReady` then high → first result delivered and `peakValid` drops.
- A drain and a new peak in the same cycle → `peakValid` stays 1 with the new data; `overflow`=0.
- `abort` in HOLDOFF → IDLE next cycle, no `done`, pending result still delivered; `arm` while `busy` ignored.
- With `PEAK_CTRL_TIMEOUT_EN` defined, `cfgTimeout`=10 and no peak → `timedOut`=1 and `done` after 10 WAIT cycles.
